// File: rtl/spiker_stream_pkg.sv
// Shared types and helpers for the spiker stream reader.
// Optional preload (shadow frame) support is enabled with SPIKER_READER_PRELOAD_EN.
package spiker_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/spiker_stream_reader_if.sv
// Beat stream between the spike reader (master) and the spiker core (slave).
interface spiker_stream_reader_if #(
  parameter int CHUNK = 4
) ();

  logic [CHUNK-1:0] chunk;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output chunk, output valid, output last, input ready);
  modport slave  (input chunk, input valid, input last, output ready);

endinterface

// File: rtl/spiker_chunk_shifter.sv
// Frame snapshot, pad masking and LSB-first shift-out for the spike reader.
// With SPIKER_READER_PRELOAD_EN a shadow register holds a preloaded frame.
module spiker_chunk_shifter #(
  parameter int DATA_W   = 800,
  parameter int N_SPIKES = 784,
  parameter int CHUNK    = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] spikes_i,
  input  logic              load,
  input  logic              shift,
  input  logic              shadow_wr,
  input  logic              shadow_to_shift,
  output logic [CHUNK-1:0]  chunk_o
);

  // Bits at or above N_SPIKES never reach the core.
  localparam logic [DATA_W-1:0] PAD_MASK = {DATA_W{1'b1}} >> (DATA_W - N_SPIKES);

  logic [DATA_W-1:0] shift_q;

`ifdef SPIKER_READER_PRELOAD_EN
  logic [DATA_W-1:0] shadow_q;

  // Shadow frame: latest start request outside IDLE wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shadow_q <= '0;
    end else if (shadow_wr) begin
      shadow_q <= spikes_i & PAD_MASK;
    end
  end

  // Shift register: fresh capture, shadow promotion or zero-filled shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= spikes_i & PAD_MASK;
    end else if (shadow_to_shift) begin
      shift_q <= shadow_q;
    end else if (shift) begin
      shift_q <= shift_q >> CHUNK;
    end
  end
`else
  logic unused_shadow;
  assign unused_shadow = shadow_wr ^ shadow_to_shift;

  // Shift register: fresh capture or zero-filled shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else if (load) begin
      shift_q <= spikes_i & PAD_MASK;
    end else if (shift) begin
      shift_q <= shift_q >> CHUNK;
    end
  end
`endif

  assign chunk_o = shift_q[CHUNK-1:0];

endmodule

// File: rtl/spiker_stream_reader.sv
// Spike frame reader: snapshots the register file on start and streams it
// to the spiker core in CHUNK-bit beats, LSB first.
// Optional preload of a second frame: SPIKER_READER_PRELOAD_EN.
//
// state  | meaning
// IDLE   | waiting for start_i; beat count holds last frame length
// LOAD   | start_o pulse, beat count cleared
// STREAM | beats offered on the stream interface
// DONE   | done_o pulse, then IDLE (or LOAD when a frame is pending)
module spiker_stream_reader
  import spiker_stream_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int N_REG    = 25,
  parameter  int N_SPIKES = 784,
  parameter  int CHUNK    = 4,
  localparam int DATA_W   = N_REG * WIDTH,
  localparam int N_BEATS  = ceil_div(N_SPIKES, CHUNK),
  localparam int BEAT_W   = $clog2(N_BEATS + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [DATA_W-1:0]     spikes_i,
  spiker_stream_reader_if.master chunk_if,
  output logic                  start_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  pending_o,
  output logic [BEAT_W-1:0]     beat_cnt_o
);

  if (N_SPIKES > DATA_W) begin : g_bad_spikes
    $error("spiker_stream_reader: N_SPIKES exceeds N_REG*WIDTH");
  end
  if (CHUNK < 1 || CHUNK > DATA_W) begin : g_bad_chunk
    $error("spiker_stream_reader: CHUNK must be 1..N_REG*WIDTH");
  end

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q;
  logic              last_beat;
  logic              load, shift_en, cnt_clr, cnt_inc;
  logic              shadow_wr, shadow_to_shift;
  logic [CHUNK-1:0]  chunk_w;

  assign last_beat = (beat_cnt_q == BEAT_W'(N_BEATS - 1));

`ifdef SPIKER_READER_PRELOAD_EN
  logic pending_q, pend_set, pend_clr;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next state and datapath strobes; abort overrides everything.
  always_comb begin
    state_d         = state_q;
    load            = 1'b0;
    shift_en        = 1'b0;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    shadow_wr       = 1'b0;
    shadow_to_shift = 1'b0;
`ifdef SPIKER_READER_PRELOAD_EN
    pend_set        = 1'b0;
    pend_clr        = 1'b0;
`endif
    if (abort_i) begin
      state_d = IDLE;
`ifdef SPIKER_READER_PRELOAD_EN
      pend_clr = 1'b1;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            load    = 1'b1;
            state_d = LOAD;
          end
        end
        LOAD: begin
          cnt_clr = 1'b1;
          state_d = STREAM;
        end
        STREAM: begin
          if (chunk_if.ready) begin
            shift_en = 1'b1;
            cnt_inc  = 1'b1;
            if (last_beat) state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
`ifdef SPIKER_READER_PRELOAD_EN
          if (pending_q) begin
            shadow_to_shift = 1'b1;
            pend_clr        = 1'b1;
            state_d         = LOAD;
          end
`endif
        end
        default: state_d = IDLE;
      endcase
`ifdef SPIKER_READER_PRELOAD_EN
      // A start while busy (including the DONE that promotes the shadow) preloads.
      if (start_i && state_q != IDLE) begin
        shadow_wr = 1'b1;
        pend_set  = 1'b1;
      end
`endif
    end
  end

  // Beat counter: cleared in LOAD, counts accepted beats, holds in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      beat_cnt_q <= '0;
    else if (cnt_clr) beat_cnt_q <= '0;
    else if (cnt_inc) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
  end

`ifdef SPIKER_READER_PRELOAD_EN
  // Pending flag; a new preload in the promoting DONE cycle wins over the clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       pending_q <= 1'b0;
    else if (pend_set) pending_q <= 1'b1;
    else if (pend_clr) pending_q <= 1'b0;
  end
  assign pending_o = pending_q;
`else
  assign pending_o = 1'b0;
`endif

  spiker_chunk_shifter #(
    .DATA_W  (DATA_W),
    .N_SPIKES(N_SPIKES),
    .CHUNK   (CHUNK)
  ) u_shifter (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .spikes_i       (spikes_i),
    .load           (load),
    .shift          (shift_en),
    .shadow_wr      (shadow_wr),
    .shadow_to_shift(shadow_to_shift),
    .chunk_o        (chunk_w)
  );

  assign chunk_if.chunk = chunk_w;
  assign chunk_if.valid = (state_q == STREAM);
  assign chunk_if.last  = (state_q == STREAM) && last_beat;
  assign start_o        = (state_q == LOAD);
  assign done_o         = (state_q == DONE);
  assign busy_o         = (state_q != IDLE);
  assign beat_cnt_o     = beat_cnt_q;

endmodule
